// File: rtl/accum_vec.sv
// Multi-lane grouped accumulator: LANES signed partial products summed per
// first/last-framed group, with optional saturation, sticky overflow and beat count.
module accum_vec #(
  parameter int LANES    = 4,
  parameter int DATAW    = 16,
  parameter int ACCUMW   = 32,
  parameter int SATURATE = 0,
  parameter int CNTW     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*DATAW-1:0]   data,
  input  logic                     ivalid,
  input  logic                     first,
  input  logic                     last,
  output logic                     iready,
  output logic [LANES*ACCUMW-1:0]  result,
  output logic [LANES-1:0]         ovf,
  output logic [CNTW-1:0]          count,
  output logic                     ovalid,
  input  logic                     oready
);

  localparam logic [ACCUMW-1:0] ACC_MAX = {1'b0, {(ACCUMW-1){1'b1}}};
  localparam logic [ACCUMW-1:0] ACC_MIN = {1'b1, {(ACCUMW-1){1'b0}}};

  // Handshake: a beat transfers when ivalid && iready; a result transfers when
  // ovalid && oready. The whole pipeline advances on en, so a stalled result
  // freezes stage 1 and the accumulators and withholds iready.
  logic en;
  assign en     = !ovalid || oready;
  assign iready = en;

  logic [LANES*DATAW-1:0]  s1_data;
  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;

  logic [LANES*ACCUMW-1:0] acc;
  logic [LANES-1:0]        ovf_acc;
  logic [CNTW-1:0]         cnt;

  logic [LANES*ACCUMW-1:0] acc_nxt;
  logic [LANES-1:0]        ovf_nxt;
  logic [CNTW-1:0]         cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_data  <= data;
      s1_valid <= ivalid && iready;
      s1_first <= first;
      s1_last  <= last;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATAW-1:0] d_l;
    logic [ACCUMW-1:0]       a_l;
    logic [ACCUMW-1:0]       ext;
    logic [ACCUMW:0]         sum;
    logic                    lane_ovf;

    assign d_l = s1_data[g*DATAW +: DATAW];
    assign a_l = acc[g*ACCUMW +: ACCUMW];
    assign ext = ACCUMW'(d_l);
    assign sum = {a_l[ACCUMW-1], a_l} + {ext[ACCUMW-1], ext};
    // With both operands sign-extended by one bit, overflow shows as the two
    // top bits disagreeing; the extra bit holds the true sign of the sum.
    assign lane_ovf = sum[ACCUMW] ^ sum[ACCUMW-1];

    assign acc_nxt[g*ACCUMW +: ACCUMW] =
        s1_first                      ? ext :
        (SATURATE != 0 && lane_ovf)   ? (sum[ACCUMW] ? ACC_MIN : ACC_MAX) :
                                        sum[ACCUMW-1:0];
    assign ovf_nxt[g] = !s1_first && (ovf_acc[g] || lane_ovf);
  end

  assign cnt_nxt = s1_first ? CNTW'(1) : cnt + CNTW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ovf_acc <= '0;
      cnt     <= '0;
    end else if (en && s1_valid) begin
      acc     <= acc_nxt;
      ovf_acc <= ovf_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Output register carries the post-update sums so the last beat is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      ovf    <= '0;
      count  <= '0;
      ovalid <= 1'b0;
    end else if (en) begin
      ovalid <= s1_valid && s1_last;
      if (s1_valid && s1_last) begin
        result <= acc_nxt;
        ovf    <= ovf_nxt;
        count  <= cnt_nxt;
      end
    end
  end

endmodule

// File: doc/accum_vec.md
Name: accum_vec

Overview:
- Parametrised multi-lane successor to the single-lane accumulator in the MVM datapath.
- Accumulates LANES signed partial products in parallel, grouped by first/last framing.
- Adds optional saturation, a per-lane sticky overflow flag, a beat counter, and a valid/ready backpressure handshake.
- Sits between the dot-product lanes and the output writeback / FIFO.

Parameters:
- LANES, 4, number of parallel accumulation lanes.
- DATAW, 16, signed input width per lane.
- ACCUMW, 32, signed accumulator and result width per lane; must be >= DATAW.
- SATURATE, 0, 0 = two's-complement wrap, 1 = clamp to the ACCUMW signed range.
- CNTW, 8, width of the beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- data  in  LANES*DATAW  signed lane data; lane i is data[i*DATAW +: DATAW].
- ivalid  in  1  input beat valid.
- first  in  1  beat starts a new group (qualified by ivalid).
- last  in  1  beat ends the group (qualified by ivalid).
- iready  out  1  block can accept a beat this cycle.
- result  out  LANES*ACCUMW  per-lane group sums, same packing as data.
- ovf  out  LANES  per-lane sticky overflow for the reported group.
- count  out  CNTW  number of beats in the reported group.
- ovalid  out  1  result/ovf/count valid.
- oready  in  1  downstream accepts the result.

Behaviour:
- Reset is synchronous on clk with rst=1 (decided).
- Reset clears all registers: result=0, ovf=0, count=0, ovalid=0, and all internal pipeline valids=0.
- iready=1 in the cycle after reset deasserts.
- Reset mid-group discards the partial sums; no output is produced for that group.
- Global enable: en = !ovalid || oready. iready = en, purely combinational from ovalid and oready.
- A beat is accepted when ivalid && iready.
- Pipeline stage 1 (input register): on en, capture data, ivalid && iready, first, last. When en=0, hold all stage-1 contents.
- Pipeline stage 2 (accumulate, on en with a valid stage-1 beat), per lane:
  - Sign-extend the data to ACCUMW.
  - first=1: acc = ext(data), ovf_acc = 0, cnt = 1.
  - first=0: acc = acc + ext(data), computed at ACCUMW+1 bits; cnt = cnt + 1, wrapping modulo 2^CNTW.
  - Overflow = the two operands have equal sign and the sum sign differs. Sets ovf_acc sticky until the next first.
  - SATURATE=1: on overflow, clamp to 2^(ACCUMW-1)-1 for positive or -2^(ACCUMW-1) for negative.
  - SATURATE=0: keep the wrapped sum.
- Beat with first=1 and last=1: a one-beat group; result = ext(data), count=1, ovf=0.
- Beat with neither flag, and no first seen since reset: adds to acc=0. Legal, no error.
- Output register, on en:
  - If the stage-1 beat is valid with last=1: load result/ovf/count with the post-update values (includes the last beat) and set ovalid=1.
  - Otherwise ovalid=0.
- Latency: a beat accepted with last in cycle t gives ovalid=1 in cycle t+2 when oready stays high.
- Backpressure: while ovalid=1 and oready=0, the result, ovf, count, ovalid, stage 1 and the accumulators all hold, and iready=0.
- The handshake completes on the first cycle with ovalid && oready. The pipeline advances that same cycle, so full throughput is one beat per cycle with oready=1.
- ivalid=0 beats are bubbles: the accumulators hold. Bubbles may appear anywhere inside a group.
- Back-to-back groups (last followed immediately by first) need no idle cycle.
- All lanes share the control signals; overflow and saturation are evaluated independently per lane.

Test Plan:
- LANES=4, DATAW=16, ACCUMW=32, SATURATE=0, oready=1. Four beats, first on beat 0 and last on beat 3; lane i data = i+1, -2, 3, 4 (lane 0: 1,-2,3,4). -> ovalid=1 two cycles after the last beat, for exactly 1 cycle; lane 0 result=6, count=4, ovf=0.
- One-beat group (first=last=1, lane data = -7, 0, 32767, -32768). -> result = -7, 0, 32767, -32768 sign-extended; count=1.
- ACCUMW=DATAW=16, SATURATE=1, lane 0 sums 32767 then 1. -> result=32767, ovf[0]=1. Same stimulus with SATURATE=0 -> result=-32768, ovf[0]=1. Next group starting with first -> ovf[0]=0.
- Group of 3 beats; hold oready=0 for 5 cycles after ovalid rises. -> result stable and iready=0 for those 5 cycles. A beat offered during the stall is accepted only after the ovalid&&oready cycle. Next group's sum is correct and no beat is lost or duplicated.
- Two groups back-to-back (last then first next cycle) with random ivalid bubbles inside a group. -> two results match a reference model, and counts exclude the bubbles.
- Assert rst during beat 2 of a 4-beat group, then send a fresh 2-beat group. -> no ovalid for the aborted group; the new result equals the 2-beat sum; all outputs are 0 the cycle after reset.
